fetch_seq: RTL and testbench

Fetch sequencer and PC owner for the 16-bit core. It holds the program counter and runs instruction-memory fetch transactions at word (2-byte) steps. It presents each fetched instruction to decode through a one-entry valid/ready buffer. It applies branch/jump redirects from execute, squashing wrong-path fetches, and parks the front end permanently on HALT.

---
 rtl/fetch_seq_if.sv | 27 ++
 rtl/fetch_seq.sv | 114 +++++++++++
 tb/tb_fetch_seq.sv | 248 ++++++++++++++++++++++++
 3 files changed

// File: rtl/fetch_seq_if.sv
// Fetch sequencer bus bundle: instruction-memory port, decode buffer port,
// execute redirect and halt controls, and architectural status.
interface fetch_seq_if;
    logic        fetch_req;
    logic [15:0] fetch_addr;
    logic        fetch_done;
    logic [15:0] fetch_instr;
    logic        instr_valid;
    logic [15:0] instr;
    logic [15:0] instr_pc;
    logic        instr_ready;
    logic        redir_valid;
    logic [15:0] redir_addr;
    logic        halt;
    logic        halted;
    logic [15:0] pc;

    modport master (
        output fetch_req, fetch_addr, instr_valid, instr, instr_pc, halted, pc,
        input  fetch_done, fetch_instr, instr_ready, redir_valid, redir_addr, halt
    );

    modport slave (
        input  fetch_req, fetch_addr, instr_valid, instr, instr_pc, halted, pc,
        output fetch_done, fetch_instr, instr_ready, redir_valid, redir_addr, halt
    );
endinterface

// File: rtl/fetch_seq.sv
// Fetch sequencer and PC owner: one outstanding instruction fetch, a one-entry
// decode buffer, redirect squashing and a permanent halt park.
module fetch_seq #(
    parameter logic [15:0] RESET_PC = 16'h0000
) (
    input  logic         clk,
    input  logic         rst,
    fetch_seq_if.master  bus
);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_FETCH  = 3'd1;
    localparam logic [2:0] S_VALID  = 3'd2;
    localparam logic [2:0] S_DRAIN  = 3'd3;
    localparam logic [2:0] S_HALTED = 3'd4;

    logic [2:0]  r_state;
    logic [15:0] r_pc;
    logic [15:0] r_req_addr;
    logic [15:0] r_instr;
    logic [15:0] r_instr_pc;
    logic        r_squash;

    logic [15:0] w_target;
    logic [15:0] w_pc_inc;

    assign w_target = {bus.redir_addr[15:1], 1'b0};
    assign w_pc_inc = r_pc + 16'd2;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state    <= S_IDLE;
            r_pc       <= RESET_PC;
            r_req_addr <= RESET_PC;
            r_instr    <= '0;
            r_instr_pc <= '0;
            r_squash   <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (bus.halt) begin
                        r_state <= S_HALTED;
                    end else begin
                        r_state <= S_FETCH;
                        if (bus.redir_valid) begin
                            r_pc       <= w_target;
                            r_req_addr <= w_target;
                        end else begin
                            r_req_addr <= r_pc;
                        end
                    end
                end
                S_FETCH: begin
                    // Address stays put until fetch_done; redirects only move pc
                    // and mark the in-flight word for discard.
                    if (bus.halt) begin
                        r_squash <= 1'b0;
                        r_state  <= bus.fetch_done ? S_HALTED : S_DRAIN;
                    end else if (bus.redir_valid) begin
                        r_pc <= w_target;
                        if (bus.fetch_done) begin
                            r_req_addr <= w_target;
                            r_squash   <= 1'b0;
                        end else begin
                            r_squash   <= 1'b1;
                        end
                    end else if (bus.fetch_done) begin
                        if (r_squash) begin
                            r_squash   <= 1'b0;
                            r_req_addr <= r_pc;
                        end else begin
                            r_instr    <= bus.fetch_instr;
                            r_instr_pc <= r_req_addr;
                            r_pc       <= w_pc_inc;
                            r_state    <= S_VALID;
                        end
                    end
                end
                S_VALID: begin
                    if (bus.halt) begin
                        r_state <= S_HALTED;
                    end else if (bus.redir_valid) begin
                        r_pc       <= w_target;
                        r_req_addr <= w_target;
                        r_state    <= S_FETCH;
                    end else if (bus.instr_ready) begin
                        r_req_addr <= r_pc;
                        r_state    <= S_FETCH;
                    end
                end
                S_DRAIN: begin
                    if (bus.fetch_done) begin
                        r_state <= S_HALTED;
                    end
                end
                S_HALTED: begin
                    r_state <= S_HALTED;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.fetch_req   = (r_state == S_FETCH) || (r_state == S_DRAIN);
    assign bus.fetch_addr  = r_req_addr;
    assign bus.instr_valid = (r_state == S_VALID);
    assign bus.instr       = r_instr;
    assign bus.instr_pc    = r_instr_pc;
    assign bus.halted      = (r_state == S_HALTED);
    assign bus.pc          = r_pc;

endmodule

// File: tb/tb_fetch_seq.sv
// Directed bench for fetch_seq with a wait-state instruction memory whose word
// at address A is A ^ 16'hA5A5.
module tb_fetch_seq;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   n_run  = 0;
    int   n_fail = 0;
    int   waits  = 0;
    int   cnt    = 0;

    fetch_seq_if u_if ();

    fetch_seq #(.RESET_PC(16'h0000)) dut (
        .clk (clk),
        .rst (rst),
        .bus (u_if)
    );

    always #5 clk = ~clk;

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            u_if.fetch_done  <= 1'b0;
            u_if.fetch_instr <= '0;
            cnt              <= 0;
        end else if (u_if.fetch_req && !u_if.fetch_done) begin
            if (cnt >= waits) begin
                u_if.fetch_done  <= 1'b1;
                u_if.fetch_instr <= u_if.fetch_addr ^ 16'hA5A5;
                cnt              <= 0;
            end else begin
                cnt <= cnt + 1;
            end
        end else begin
            u_if.fetch_done <= 1'b0;
        end
    end

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst = 1'b0;
        u_if.instr_ready = 1'b0;
        u_if.redir_valid = 1'b0;
        u_if.redir_addr  = '0;
        u_if.halt        = 1'b0;
        waits            = 0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic wait_valid(input string tag);
        for (int i = 0; i < 40; i++) begin
            if (u_if.instr_valid) return;
            tick();
        end
        n_run++; n_fail++;
        $display("FAIL %s_timeout: got no instr_valid, want instr_valid within 40 cycles", tag);
    endtask

    task automatic wait_done(input string tag, input logic [15:0] hold_addr);
        for (int i = 0; i < 40; i++) begin
            if (u_if.fetch_done) return;
            n_run++;
            if (u_if.fetch_addr !== hold_addr || u_if.fetch_req !== 1'b1 || u_if.instr_valid !== 1'b0) begin
                n_fail++;
                $display("FAIL %s_hold: got req=%b addr=%h valid=%b, want req=1 addr=%h valid=0",
                         tag, u_if.fetch_req, u_if.fetch_addr, u_if.instr_valid, hold_addr);
            end
            tick();
        end
        n_run++; n_fail++;
        $display("FAIL %s_timeout: got no fetch_done, want fetch_done within 40 cycles", tag);
    endtask

    task automatic test_reset();
        do_reset();
        u_if.instr_ready = 1'b1;
        n_run++; if (u_if.fetch_req !== 1'b0) begin n_fail++; $display("FAIL rst_idle_req: got %b want 0", u_if.fetch_req); end
        tick();
        n_run++; if (u_if.fetch_req !== 1'b1) begin n_fail++; $display("FAIL rst_first_req: got %b want 1", u_if.fetch_req); end
        n_run++; if (u_if.fetch_addr !== 16'h0000) begin n_fail++; $display("FAIL rst_first_addr: got %h want 0000", u_if.fetch_addr); end
        wait_valid("rst");
        tick();
        #2 rst = 1'b0;
        #1;
        n_run++; if (u_if.fetch_req !== 1'b0) begin n_fail++; $display("FAIL rst_async_req: got %b want 0", u_if.fetch_req); end
        n_run++; if (u_if.pc !== 16'h0000) begin n_fail++; $display("FAIL rst_pc: got %h want 0000", u_if.pc); end
        n_run++; if (u_if.fetch_addr !== 16'h0000) begin n_fail++; $display("FAIL rst_addr: got %h want 0000", u_if.fetch_addr); end
        n_run++; if (u_if.instr !== 16'h0000 || u_if.instr_pc !== 16'h0000) begin n_fail++; $display("FAIL rst_buf: got instr=%h pc=%h want 0000 0000", u_if.instr, u_if.instr_pc); end
        n_run++; if (u_if.instr_valid !== 1'b0 || u_if.halted !== 1'b0) begin n_fail++; $display("FAIL rst_flags: got valid=%b halted=%b want 0 0", u_if.instr_valid, u_if.halted); end
    endtask

    task automatic test_sequential();
        int          cyc_q[$];
        logic [15:0] pc_q[$];
        logic [15:0] ins_q[$];
        logic [15:0] exp_pc;
        do_reset();
        u_if.instr_ready = 1'b1;
        for (int c = 0; c < 30 && cyc_q.size() < 4; c++) begin
            if (u_if.instr_valid) begin
                cyc_q.push_back(c);
                pc_q.push_back(u_if.instr_pc);
                ins_q.push_back(u_if.instr);
            end
            tick();
        end
        n_run++;
        if (cyc_q.size() != 4) begin
            n_fail++; $display("FAIL seq_count: got %0d instructions want 4", cyc_q.size());
        end else begin
            for (int k = 0; k < 4; k++) begin
                exp_pc = 16'(2 * k);
                n_run++; if (pc_q[k] !== exp_pc) begin n_fail++; $display("FAIL seq_pc%0d: got %h want %h", k, pc_q[k], exp_pc); end
                n_run++; if (ins_q[k] !== (exp_pc ^ 16'hA5A5)) begin n_fail++; $display("FAIL seq_instr%0d: got %h want %h", k, ins_q[k], exp_pc ^ 16'hA5A5); end
                if (k > 0) begin
                    n_run++; if (cyc_q[k] - cyc_q[k-1] != 3) begin n_fail++; $display("FAIL seq_gap%0d: got %0d want 3", k, cyc_q[k] - cyc_q[k-1]); end
                end
            end
        end
    endtask

    task automatic test_stall();
        do_reset();
        wait_valid("stall");
        for (int i = 0; i < 5; i++) begin
            n_run++;
            if (u_if.instr !== 16'hA5A5 || u_if.instr_pc !== 16'h0000 || u_if.instr_valid !== 1'b1 || u_if.fetch_req !== 1'b0) begin
                n_fail++;
                $display("FAIL stall_hold%0d: got instr=%h pc=%h valid=%b req=%b want A5A5 0000 1 0",
                         i, u_if.instr, u_if.instr_pc, u_if.instr_valid, u_if.fetch_req);
            end
            tick();
        end
        u_if.instr_ready = 1'b1;
        tick();
        u_if.instr_ready = 1'b0;
        n_run++; if (u_if.fetch_req !== 1'b1 || u_if.fetch_addr !== 16'h0002) begin n_fail++; $display("FAIL stall_next: got req=%b addr=%h want 1 0002", u_if.fetch_req, u_if.fetch_addr); end
        n_run++; if (u_if.instr_valid !== 1'b0) begin n_fail++; $display("FAIL stall_flush: got valid=%b want 0", u_if.instr_valid); end
    endtask

    task automatic test_redirect_wait();
        do_reset();
        u_if.instr_ready = 1'b1;
        wait_valid("redir");
        waits            = 4;
        u_if.redir_valid = 1'b1;
        u_if.redir_addr  = 16'h0010;
        tick();
        n_run++; if (u_if.fetch_addr !== 16'h0010 || u_if.pc !== 16'h0010) begin n_fail++; $display("FAIL redir_setup: got addr=%h pc=%h want 0010 0010", u_if.fetch_addr, u_if.pc); end
        u_if.redir_addr = 16'h0101;
        tick();
        u_if.redir_valid = 1'b0;
        n_run++; if (u_if.pc !== 16'h0100) begin n_fail++; $display("FAIL redir_pc: got %h want 0100", u_if.pc); end
        wait_done("redir", 16'h0010);
        tick();
        waits = 0;
        n_run++; if (u_if.fetch_req !== 1'b1 || u_if.fetch_addr !== 16'h0100) begin n_fail++; $display("FAIL redir_refetch: got req=%b addr=%h want 1 0100", u_if.fetch_req, u_if.fetch_addr); end
        n_run++; if (u_if.instr_valid !== 1'b0) begin n_fail++; $display("FAIL redir_dropped: got valid=%b want 0", u_if.instr_valid); end
        wait_valid("redir2");
        n_run++; if (u_if.instr_pc !== 16'h0100 || u_if.instr !== 16'hA4A5) begin n_fail++; $display("FAIL redir_present: got pc=%h instr=%h want 0100 A4A5", u_if.instr_pc, u_if.instr); end
    endtask

    task automatic test_same_cycle();
        do_reset();
        u_if.instr_ready = 1'b1;
        wait_valid("same");
        tick();
        wait_done("same", 16'h0002);
        u_if.redir_valid = 1'b1;
        u_if.redir_addr  = 16'h0041;
        tick();
        u_if.redir_valid = 1'b0;
        n_run++; if (u_if.fetch_req !== 1'b1 || u_if.fetch_addr !== 16'h0040) begin n_fail++; $display("FAIL same_refetch: got req=%b addr=%h want 1 0040", u_if.fetch_req, u_if.fetch_addr); end
        n_run++; if (u_if.instr_valid !== 1'b0 || u_if.pc !== 16'h0040) begin n_fail++; $display("FAIL same_drop: got valid=%b pc=%h want 0 0040", u_if.instr_valid, u_if.pc); end
        wait_valid("same2");
        n_run++; if (u_if.instr_pc !== 16'h0040 || u_if.instr !== 16'hA5E5) begin n_fail++; $display("FAIL same_present: got pc=%h instr=%h want 0040 A5E5", u_if.instr_pc, u_if.instr); end
    endtask

    task automatic test_halt();
        do_reset();
        u_if.instr_ready = 1'b1;
        wait_valid("halt");
        waits = 3;
        tick();
        u_if.halt        = 1'b1;
        u_if.redir_valid = 1'b1;
        u_if.redir_addr  = 16'h0200;
        tick();
        u_if.halt        = 1'b0;
        u_if.redir_valid = 1'b0;
        n_run++; if (u_if.pc !== 16'h0002 || u_if.halted !== 1'b0) begin n_fail++; $display("FAIL halt_drain: got pc=%h halted=%b want 0002 0", u_if.pc, u_if.halted); end
        wait_done("halt", 16'h0002);
        tick();
        u_if.redir_valid = 1'b1;
        u_if.redir_addr  = 16'h0300;
        for (int i = 0; i < 4; i++) begin
            n_run++;
            if (u_if.halted !== 1'b1 || u_if.fetch_req !== 1'b0 || u_if.instr_valid !== 1'b0 || u_if.pc !== 16'h0002) begin
                n_fail++;
                $display("FAIL halt_park%0d: got halted=%b req=%b valid=%b pc=%h want 1 0 0 0002",
                         i, u_if.halted, u_if.fetch_req, u_if.instr_valid, u_if.pc);
            end
            tick();
        end
        u_if.redir_valid = 1'b0;
        #2 rst = 1'b0;
        #1;
        n_run++; if (u_if.pc !== 16'h0000 || u_if.halted !== 1'b0) begin n_fail++; $display("FAIL halt_reset: got pc=%h halted=%b want 0000 0", u_if.pc, u_if.halted); end
    endtask

    task automatic test_wrap();
        do_reset();
        u_if.instr_ready = 1'b1;
        wait_valid("wrap");
        u_if.redir_valid = 1'b1;
        u_if.redir_addr  = 16'hFFFE;
        tick();
        u_if.redir_valid = 1'b0;
        n_run++; if (u_if.fetch_addr !== 16'hFFFE) begin n_fail++; $display("FAIL wrap_addr: got %h want FFFE", u_if.fetch_addr); end
        wait_valid("wrap2");
        n_run++; if (u_if.instr_pc !== 16'hFFFE || u_if.pc !== 16'h0000) begin n_fail++; $display("FAIL wrap_pc: got instr_pc=%h pc=%h want FFFE 0000", u_if.instr_pc, u_if.pc); end
        tick();
        n_run++; if (u_if.fetch_req !== 1'b1 || u_if.fetch_addr !== 16'h0000) begin n_fail++; $display("FAIL wrap_next: got req=%b addr=%h want 1 0000", u_if.fetch_req, u_if.fetch_addr); end
    endtask

    initial begin
        u_if.instr_ready = 1'b0;
        u_if.redir_valid = 1'b0;
        u_if.redir_addr  = '0;
        u_if.halt        = 1'b0;
        test_reset();
        test_sequential();
        test_stall();
        test_redirect_wait();
        test_same_cycle();
        test_halt();
        test_wrap();
        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule
